// File: rtl/core_pkg.sv
// Shared core constants: default datapath width, instruction width, PC step and
// the zero instruction driven on idle decode ports.
package core_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ILEN     = 32;
  localparam int PC_INC   = 4;

  localparam logic [ILEN-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch queue: power-of-two circular buffer with synchronous push/pop/clear,
// asynchronous control reset. Push while full is accepted only alongside a pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_full;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~w_full | w_pop);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited sequential fetch into a small queue,
// redirect flush with in-flight response discard. Optional perf counters are
// built only when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import core_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter int              BUF_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
);

  localparam int              CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INC);

  logic [XLEN-1:0]   r_fpc;
  logic [XLEN-1:0]   r_rsp_pc;
  logic [CW-1:0]     r_outst;
  logic [CW-1:0]     r_discard;
  logic [CW-1:0]     w_occ;
  logic [CW:0]       w_inflight;
  logic              w_req_fire;
  logic              w_rsp_keep;
  logic              w_pop;
  logic              w_empty;
  logic [2*XLEN-1:0] w_head;

  // Every issued request owns a queue slot, so the queue can never overflow.
  assign w_inflight     = {1'b0, w_occ} + {1'b0, r_outst};
  assign imem_req_valid = ~rst & ~redirect_valid & (w_inflight < (CW+1)'(BUF_DEPTH));
  assign imem_req_addr  = r_fpc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  assign w_rsp_keep  = imem_rsp_valid & (r_discard == '0) & ~redirect_valid;
  assign instr_valid = ~w_empty;
  assign w_pop       = instr_valid & instr_ready & ~redirect_valid;
  assign instr_pc    = instr_valid ? w_head[2*XLEN-1:XLEN] : '0;
  assign instr       = instr_valid ? w_head[XLEN-1:0] : XLEN'(NOP_INSTR);

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (redirect_valid),
    .i_push  (w_rsp_keep),
    .i_data  ({r_rsp_pc, imem_rsp_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fpc     <= RESET_PC;
      r_rsp_pc  <= RESET_PC;
      r_outst   <= '0;
      r_discard <= '0;
    end else if (redirect_valid) begin
      // A response landing this cycle is dropped here, the rest are discarded later.
      r_fpc     <= redirect_pc;
      r_rsp_pc  <= redirect_pc;
      r_outst   <= r_outst - CW'(imem_rsp_valid);
      r_discard <= r_outst - CW'(imem_rsp_valid);
    end else begin
      if (w_req_fire) r_fpc <= r_fpc + PC_STEP;
      if (w_rsp_keep) r_rsp_pc <= r_rsp_pc + PC_STEP;
      if (imem_rsp_valid && (r_discard != '0)) r_discard <= r_discard - CW'(1);
      r_outst <= r_outst + CW'(w_req_fire) - CW'(imem_rsp_valid);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (instr_valid && !instr_ready) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (redirect_valid)              r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model with random latency/backpressure,
// scoreboard of expected {pc, word} stream, directed corner cases plus random run.
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam int          XLEN      = 32;
  localparam int          BUF_DEPTH = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  fetch_stage #(.XLEN(XLEN), .BUF_DEPTH(BUF_DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Expected decode stream: consecutive PCs from the latest reset/redirect target.
  typedef struct packed { logic [31:0] pc; logic [31:0] word; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] exp_next = RESET_PC;

  always @(posedge clk) begin
    #3;
    while (exp_q.size() < 16) begin
      exp_q.push_back({exp_next, mem_word(exp_next)});
      exp_next += 32'd4;
    end
  end

  // Memory model: in-order responses, latency lat_min..lat_max cycles.
  int unsigned cyc = 0, lat_min = 1, lat_max = 1, rdy_pct = 100, req_cnt = 0;
  logic [31:0] pend_addr[$];
  int unsigned pend_due[$];
  logic [31:0] fetch_exp = RESET_PC;

  initial begin
    int unsigned due;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst && pend_due.size() > 0 && pend_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
        fetch_exp = RESET_PC;
        req_cnt   = 0;
      end else begin
        if (redirect_valid) check("req_during_redirect", 64'(imem_req_valid), 64'd0);
        if (imem_req_valid && imem_req_ready) begin
          check("req_addr", 64'(imem_req_addr), 64'(fetch_exp));
          fetch_exp += 32'd4;
          req_cnt++;
          due = cyc + $urandom_range(lat_min, lat_max);
          if (pend_due.size() > 0 && due < pend_due[$]) due = pend_due[$];
          pend_addr.push_back(imem_req_addr);
          pend_due.push_back(due);
        end
        if (redirect_valid) fetch_exp = redirect_pc;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted instruction, checks hold/idle/perf.
  int unsigned stall_m = 0, flush_m = 0;
  logic        hold_pend = 1'b0;
  logic [63:0] hold_val;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_m = 0; flush_m = 0; hold_pend = 1'b0;
      end else begin
`ifdef FETCH_PERF_CNT_EN
        check("perf_stall", 64'(perf_stall_cnt), 64'(stall_m));
        check("perf_flush", 64'(perf_flush_cnt), 64'(flush_m));
`else
        check("perf_stall_off", 64'(perf_stall_cnt), 64'd0);
        check("perf_flush_off", 64'(perf_flush_cnt), 64'd0);
`endif
        if (hold_pend) begin
          check("hold_valid", 64'(instr_valid), 64'd1);
          check("hold_data", {instr_pc, instr}, hold_val);
        end
        if (!instr_valid) check("idle_zero", {instr_pc, instr}, 64'd0);
        if (instr_valid && instr_ready && !redirect_valid) begin
          if (exp_q.size() == 0) check("sb_nonempty", 64'd0, 64'd1);
          else begin
            e = exp_q.pop_front();
            check("instr_pc", 64'(instr_pc), 64'(e.pc));
            check("instr", 64'(instr), 64'(e.word));
          end
        end
        hold_pend = instr_valid && !instr_ready && !redirect_valid;
        hold_val  = {instr_pc, instr};
        if (instr_valid && !instr_ready && stall_m != 32'hFFFF_FFFF) stall_m++;
        if (redirect_valid && flush_m != 32'hFFFF_FFFF) flush_m++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_checks();
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_req_addr", 64'(imem_req_addr), 64'(RESET_PC));
    check("rst_instr_valid", 64'(instr_valid), 64'd0);
    check("rst_instr", {instr_pc, instr}, 64'd0);
    check("rst_perf", {perf_stall_cnt, perf_flush_cnt}, 64'd0);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    redirect_valid = 1'b0;
    exp_q.delete();
    exp_next = RESET_PC;
    #1;
    reset_checks();
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic redirect_now(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    exp_q.delete();
    exp_next = t;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    // Reset state.
    @(posedge clk);
    #2;
    reset_checks();

    // Back-to-back stream, latency 1, first valid two cycles after first request.
    instr_ready = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("first_req_valid", 64'(imem_req_valid), 64'd1);
    check("first_c0_valid", 64'(instr_valid), 64'd0);
    @(negedge clk);
    check("first_c1_valid", 64'(instr_valid), 64'd0);
    @(negedge clk);
    check("first_c2_valid", 64'(instr_valid), 64'd1);
    check("first_pc", 64'(instr_pc), 64'(RESET_PC));
    repeat (8) begin
      @(negedge clk);
      check("b2b_valid", 64'(instr_valid), 64'd1);
    end

    // Decode stalled: queue fills, exactly BUF_DEPTH requests, head held.
    instr_ready = 1'b0;
    do_reset();
    for (k = 0; k < 20 && !instr_valid; k++) @(negedge clk);
    check("stall_fill_valid", 64'(instr_valid), 64'd1);
    repeat (10) @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt_10", 64'(perf_stall_cnt), 64'd10);
`else
    check("stall_cnt_off", 64'(perf_stall_cnt), 64'd0);
`endif
    check("stall_req_cnt", 64'(req_cnt), 64'(BUF_DEPTH));
    check("stall_no_req", 64'(imem_req_valid), 64'd0);
    check("stall_head_pc", 64'(instr_pc), 64'(RESET_PC));
    check("stall_head_instr", 64'(instr), 64'(mem_word(RESET_PC)));
    step();
    instr_ready = 1'b1;
    repeat (20) step();

    // Redirect with three requests in flight.
    lat_min = 5; lat_max = 5;
    do_reset();
    for (k = 0; k < 20 && req_cnt != 3; k++) step();
    check("three_outstanding", 64'(req_cnt), 64'd3);
    check("no_rsp_yet", 64'(imem_rsp_valid), 64'd0);
    redirect_now(32'h100);
    for (k = 0; k < 40 && !instr_valid; k++) @(negedge clk);
    check("redir_first_pc", 64'(instr_pc), 64'h100);
`ifdef FETCH_PERF_CNT_EN
    check("flush_cnt_1", 64'(perf_flush_cnt), 64'd1);
`else
    check("flush_cnt_off", 64'(perf_flush_cnt), 64'd0);
`endif
    lat_min = 1; lat_max = 1;
    repeat (10) step();

    // Redirect coinciding with a response and a pop.
    do_reset();
    repeat (6) step();
    check("coinc_pre", {62'd0, imem_rsp_valid, instr_valid}, 64'd3);
    redirect_now(32'h200);
    @(negedge clk);
    check("coinc_empty", 64'(instr_valid), 64'd0);
    check("coinc_req", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, 32'h200});
    repeat (8) step();

    // Address wrap at the top of the address space.
    redirect_now(32'hFFFF_FFF0);
    for (k = 0; k < 40 && !(instr_valid && instr_pc == 32'h0); k++) @(negedge clk);
    check("wrap_to_zero", {31'd0, instr_valid, instr_pc}, {31'd0, 1'b1, 32'h0});
    repeat (5) step();

    // Reset mid-stream: immediate zero outputs, restart at RESET_PC.
    do_reset();
    for (k = 0; k < 20 && !instr_valid; k++) @(negedge clk);
    check("restart_pc", {31'd0, instr_valid, instr_pc}, {31'd0, 1'b1, RESET_PC});
    step();

    // Randomized traffic: latency, memory backpressure, decode stalls, redirects.
    lat_min = 1; lat_max = 3; rdy_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) redirect_now($urandom & 32'hFFFF_FFFC);
      else step();
    end
    lat_min = 1; lat_max = 1; rdy_pct = 100; instr_ready = 1'b1;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath, PC and instruction width.
REQ-002 SHALL have parameter BUF_DEPTH, default 4, meaning fetch queue entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-008 SHALL have port imem_req_addr  output  XLEN  fetch address.
REQ-009 SHALL have port imem_rsp_valid  input  1  instruction word returned, in request order, latency >=1.
REQ-010 SHALL have port imem_rsp_data  input  XLEN  returned instruction word.
REQ-011 SHALL have port redirect_valid  input  1  taken branch/jump from execute, flush.
REQ-012 SHALL have port redirect_pc  input  XLEN  redirect target.
REQ-013 SHALL have port instr_valid  output  1  decode-side instruction valid.
REQ-014 SHALL have port instr_ready  input  1  decode accepts (low = stall).
REQ-015 SHALL have port instr  output  XLEN  instruction to decode.
REQ-016 SHALL have port instr_pc  output  XLEN  PC of instr.
REQ-017 SHALL have port perf_stall_cnt  output  32  cycles with instr_valid=1 and instr_ready=0.
REQ-018 SHALL have port perf_flush_cnt  output  32  accepted redirect count.

Function
REQ-019 SHALL keep fetch PC register fpc; imem_req_addr = fpc.
REQ-020 SHALL define credit = BUF_DEPTH - (queue occupancy + outstanding requests); imem_req_valid = (credit>0) & ~redirect_valid.
REQ-021 SHALL, on request handshake, increment outstanding and advance fpc by 4 (modulo 2^XLEN, wrap silently).
REQ-022 SHALL keep rsp_pc = PC of next expected response; each kept response pushes {rsp_pc, imem_rsp_data} into queue and advances rsp_pc by 4.
REQ-023 SHALL never overflow the queue; credit rule guarantees space for every outstanding response.
REQ-024 SHALL drive instr_valid = queue non-empty, instr/instr_pc = queue head; pop on instr_valid & instr_ready.
REQ-025 SHALL impose minimum latency of 1 cycle from imem_rsp_valid to instr_valid (no bypass).
REQ-026 SHALL hold instr/instr_pc stable while instr_valid=1 and instr_ready=0.
REQ-027 SHALL, when instr_valid=0, drive instr=0 and instr_pc=0.
REQ-028 SHALL, on redirect_valid, in the same edge: clear queue, set fpc and rsp_pc to redirect_pc, load discard counter with outstanding requests not yet answered (excluding a response arriving that cycle, which is also dropped).
REQ-029 SHALL drop responses while discard counter >0, decrementing it and outstanding per drop; first fetch from redirect_pc issues the cycle after redirect.
REQ-030 SHALL give redirect priority over simultaneous pop, push and request; the request offered that cycle is suppressed.
REQ-031 SHALL allow push and pop in the same cycle at any occupancy, including full.

Reset
REQ-032 SHALL asynchronously set fpc=rsp_pc=RESET_PC, queue empty, outstanding=0, discard=0, counters=0; all outputs 0 except imem_req_addr=RESET_PC.
REQ-033 SHALL abandon in-flight requests on reset; memory is reset together with this block.

Configuration
REQ-034 SHALL compile performance counters only when FETCH_PERF_CNT_EN is defined: perf_stall_cnt/perf_flush_cnt increment per REQ-017/018, saturating at 2^32-1.
REQ-035 SHALL, without FETCH_PERF_CNT_EN, tie both perf outputs to 0 and instantiate no counter flops.

Structure
REQ-036 SHALL place XLEN default, instruction width, PC increment (4), and the NOP/zero-instruction constant in shared package core_pkg.
REQ-037 SHALL implement the queue as sub-module fetch_fifo (parametrised width, depth, synchronous push/pop/clear, async reset).

Verification
REQ-038 SHALL cover: reset, memory always ready, 1-cycle latency, instr_ready=1 -> instr_pc 0x0,0x4,0x8... back-to-back, first instr_valid 2 cycles after first request.
REQ-039 SHALL cover: instr_ready=0 for 10 cycles -> exactly BUF_DEPTH(4) requests issued, queue full, head held, perf_stall_cnt=10 (macro on).
REQ-040 SHALL cover: 3 outstanding requests, redirect_pc=0x100 -> 3 responses dropped, next instr_pc=0x100, perf_flush_cnt=1.
REQ-041 SHALL cover: redirect coincident with response and pop -> response dropped, queue empty next cycle, fetch from target.
REQ-042 SHALL cover: fpc=0xFFFF_FFFC -> next request address 0x0000_0000; rst asserted mid-stream -> outputs zero immediately, restart at RESET_PC.
